// File: rtl/resource_owner_sequencer_if.sv
// Bundle of the arbiter-facing and owner-status signals of the resource owner
// sequencer. The master side drives the request/grant vectors and observes
// ownership; the slave side is the sequencer itself.
interface resource_owner_sequencer_if #(
    parameter int AGENTS = 8,
    parameter int IDW    = $clog2(AGENTS)
);
    logic [AGENTS-1:0] r;
    logic [AGENTS-1:0] g;
    logic              owner_valid;
    logic [IDW-1:0]    owner_id;
    logic [7:0]        beat;
    logic [AGENTS-1:0] done;
    logic              grant_error;
    logic [7:0]        drop_count;

    modport master (
        output r,
        output g,
        input  owner_valid,
        input  owner_id,
        input  beat,
        input  done,
        input  grant_error,
        input  drop_count
    );

    modport slave (
        input  r,
        input  g,
        output owner_valid,
        output owner_id,
        output beat,
        output done,
        output grant_error,
        output drop_count
    );
endinterface

// File: rtl/resource_owner_sequencer.sv
// Resource owner sequencer: turns a registered one-hot arbiter grant into a
// bounded tenure of BURST beats. A tenure can end early when the owner drops
// its request. The owner gets a one-cycle done pulse when its tenure ends.
// Grants that arrive while the resource is held are counted and ignored.
// Grants that are malformed raise a sticky error flag.
module resource_owner_sequencer #(
    parameter int AGENTS = 8,
    parameter int BURST  = 4,
    parameter int IDW    = $clog2(AGENTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    resource_owner_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic              owner_valid_reg;
    logic [IDW-1:0]    owner_id_reg;
    logic [7:0]        beat_reg;
    logic [AGENTS-1:0] done_reg;
    logic              grant_error_reg;
    logic [7:0]        drop_count_reg;

    // Grant decode results.
    logic [IDW-1:0]    idx_terms [AGENTS];
    logic [IDW-1:0]    grant_idx_next;
    logic              grant_any;
    logic              grant_unknown;
    logic              grant_onehot;
    logic              grant_bad;
    logic              last_beat;
    logic              owner_released;
    logic [AGENTS-1:0] owner_mask;

    // Each grant bit contributes its own index. A valid grant has only one set
    // bit, so OR-ing the contributions gives the binary owner index.
    generate
        for (genvar gi = 0; gi < AGENTS; gi++) begin : g_idx
            assign idx_terms[gi] = bus.g[gi] ? IDW'(gi) : '0;
        end
    endgenerate

    // Collapse the per-bit index contributions into a single owner index.
    always_comb begin
        grant_idx_next = '0;
        for (int i = 0; i < AGENTS; i++) begin
            grant_idx_next = grant_idx_next | idx_terms[i];
        end
    end

    // An unknown grant bit is treated as a malformed grant. Synthesis sees
    // only known values, so the unknown term drops out in hardware.
    assign grant_unknown  = $isunknown(bus.g);
    assign grant_any      = (bus.g != '0);
    assign grant_onehot   = !grant_unknown && grant_any
                            && ((bus.g & (bus.g - AGENTS'(1))) == '0);
    assign grant_bad      = grant_unknown || (grant_any && !grant_onehot);
    assign last_beat      = (beat_reg == 8'(BURST - 1));
    assign owner_released = !bus.r[owner_id_reg];
    assign owner_mask     = AGENTS'(1) << owner_id_reg;

    // Ownership FSM. All outputs are registered here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= IDLE;
            owner_valid_reg <= 1'b0;
            owner_id_reg    <= '0;
            beat_reg        <= '0;
            done_reg        <= '0;
            grant_error_reg <= 1'b0;
            drop_count_reg  <= '0;
        end else begin
            // done is high only in DONE. It is set below on the BUSY->DONE edge.
            done_reg <= '0;

            // Any grant activity while the resource is held is dropped.
            if ((state_reg != IDLE) && (grant_any || grant_unknown)
                    && (drop_count_reg != 8'hFF)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (grant_onehot) begin
                        state_reg       <= BUSY;
                        owner_valid_reg <= 1'b1;
                        owner_id_reg    <= grant_idx_next;
                        beat_reg        <= '0;
                    end else if (grant_bad) begin
                        grant_error_reg <= 1'b1;
                    end
                end

                BUSY: begin
                    // A full tenure and an early release end the same way,
                    // with a single done pulse.
                    if (last_beat || owner_released) begin
                        state_reg <= DONE;
                        done_reg  <= owner_mask;
                    end else begin
                        beat_reg <= beat_reg + 8'd1;
                    end
                end

                DONE: begin
                    state_reg       <= IDLE;
                    owner_valid_reg <= 1'b0;
                    owner_id_reg    <= '0;
                    beat_reg        <= '0;
                end

                default: begin
                    state_reg       <= IDLE;
                    owner_valid_reg <= 1'b0;
                    owner_id_reg    <= '0;
                    beat_reg        <= '0;
                end
            endcase
        end
    end

    assign bus.owner_valid = owner_valid_reg;
    assign bus.owner_id    = owner_id_reg;
    assign bus.beat        = beat_reg;
    assign bus.done        = done_reg;
    assign bus.grant_error = grant_error_reg;
    assign bus.drop_count  = drop_count_reg;

endmodule

// File: tb/tb_resource_owner_sequencer.sv
// Directed bench for resource_owner_sequencer with AGENTS=8 and BURST=4.
// Inputs change 1 time unit after each rising edge. Outputs are checked at
// the same point.
module tb_resource_owner_sequencer;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    resource_owner_sequencer_if #(.AGENTS(8)) bus ();

    resource_owner_sequencer #(
        .AGENTS(8),
        .BURST (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock with a period of 10 time units.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input logic ov, input logic [2:0] id,
                               input logic [7:0] bt, input logic [7:0] dn);
        check({tag, ".owner_valid"}, 32'(bus.owner_valid), 32'(ov));
        check({tag, ".owner_id"},    32'(bus.owner_id),    32'(id));
        check({tag, ".beat"},        32'(bus.beat),        32'(bt));
        check({tag, ".done"},        32'(bus.done),        32'(dn));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.r = '0;
        bus.g = '0;

        // Reset state.
        tick();
        tick();
        check_state("reset", 1'b0, 3'd0, 8'd0, 8'h00);
        check("reset.grant_error", 32'(bus.grant_error), 32'd0);
        check("reset.drop_count",  32'(bus.drop_count),  32'd0);
        reset = 1'b1;
        tick();
        check_state("first_edge_idle", 1'b0, 3'd0, 8'd0, 8'h00);

        // Full tenure on agent 2.
        bus.r = 8'h04;
        bus.g = 8'h04;
        tick();
        bus.g = 8'h00;
        check_state("full.b0", 1'b1, 3'd2, 8'd0, 8'h00);
        tick();
        check_state("full.b1", 1'b1, 3'd2, 8'd1, 8'h00);
        tick();
        check_state("full.b2", 1'b1, 3'd2, 8'd2, 8'h00);
        tick();
        check_state("full.b3", 1'b1, 3'd2, 8'd3, 8'h00);
        tick();
        check_state("full.done", 1'b1, 3'd2, 8'd3, 8'h04);
        tick();
        check_state("full.idle", 1'b0, 3'd0, 8'd0, 8'h00);
        bus.r = 8'h00;

        // Early release on agent 5 after two BUSY cycles.
        bus.r = 8'h20;
        bus.g = 8'h20;
        tick();
        bus.g = 8'h00;
        check_state("early.b0", 1'b1, 3'd5, 8'd0, 8'h00);
        tick();
        check_state("early.b1", 1'b1, 3'd5, 8'd1, 8'h00);
        bus.r = 8'h00;
        tick();
        check_state("early.done", 1'b1, 3'd5, 8'd1, 8'h20);
        tick();
        check_state("early.idle", 1'b0, 3'd0, 8'd0, 8'h00);

        // Dropped grants while BUSY, then one in DONE.
        bus.r = 8'h08;
        bus.g = 8'h08;
        tick();
        bus.g = 8'h01;
        check_state("drop.b0", 1'b1, 3'd3, 8'd0, 8'h00);
        tick();
        tick();
        tick();
        bus.g = 8'h00;
        check("drop.busy_count", 32'(bus.drop_count), 32'd3);
        check("drop.busy_owner", 32'(bus.owner_id),   32'd3);
        tick();
        check_state("drop.done", 1'b1, 3'd3, 8'd3, 8'h08);
        bus.g = 8'h01;
        tick();
        bus.g = 8'h00;
        check("drop.done_count", 32'(bus.drop_count),  32'd4);
        check("drop.no_accept",  32'(bus.owner_valid), 32'd0);
        bus.r = 8'h00;
        tick();
        check("drop.still_idle", 32'(bus.owner_valid), 32'd0);

        // Malformed grants: multi-hot, then a grant with an unknown bit.
        bus.g = 8'h12;
        tick();
        bus.g = 8'h00;
        check("bad.multi_error", 32'(bus.grant_error), 32'd1);
        check("bad.multi_idle",  32'(bus.owner_valid), 32'd0);
        bus.g = 8'b0001_x010;
        tick();
        bus.g = 8'h00;
        check("bad.x_error", 32'(bus.grant_error), 32'd1);
        check("bad.x_idle",  32'(bus.owner_valid), 32'd0);
        bus.r = 8'h02;
        bus.g = 8'h02;
        tick();
        bus.g = 8'h00;
        check_state("bad.tenure_b0", 1'b1, 3'd1, 8'd0, 8'h00);
        tick();
        tick();
        tick();
        tick();
        check_state("bad.tenure_done", 1'b1, 3'd1, 8'd3, 8'h02);
        tick();
        bus.r = 8'h00;
        check("bad.error_sticky", 32'(bus.grant_error), 32'd1);

        // Reset in the middle of a tenure at beat 2.
        bus.r = 8'h40;
        bus.g = 8'h40;
        tick();
        bus.g = 8'h00;
        tick();
        tick();
        check_state("rst.b2", 1'b1, 3'd6, 8'd2, 8'h00);
        reset = 1'b0;
        bus.g = 8'h01;
        tick();
        check_state("rst.cleared", 1'b0, 3'd0, 8'd0, 8'h00);
        check("rst.grant_error", 32'(bus.grant_error), 32'd0);
        check("rst.drop_count",  32'(bus.drop_count),  32'd0);
        tick();
        check_state("rst.held", 1'b0, 3'd0, 8'd0, 8'h00);
        reset = 1'b1;
        bus.g = 8'h00;
        bus.r = 8'h00;
        tick();
        check_state("rst.first_edge", 1'b0, 3'd0, 8'd0, 8'h00);
        bus.r = 8'h80;
        bus.g = 8'h80;
        tick();
        bus.g = 8'h00;
        check_state("rst.new_owner", 1'b1, 3'd7, 8'd0, 8'h00);
        tick();
        tick();
        tick();
        tick();
        check_state("rst.new_done", 1'b1, 3'd7, 8'd3, 8'h80);
        tick();
        bus.r = 8'h00;
        check("rst.new_idle", 32'(bus.owner_valid), 32'd0);

        // Saturation: holding g and r on agent 0 gives 5 drops every 6 edges,
        // so 360 edges give 300 dropped grant cycles.
        bus.r = 8'h01;
        bus.g = 8'h01;
        for (int i = 0; i < 360; i++) begin
            tick();
        end
        bus.g = 8'h00;
        bus.r = 8'h00;
        check("sat.drop_count", 32'(bus.drop_count), 32'd255);
        tick();
        check("sat.idle", 32'(bus.owner_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/resource_owner_sequencer.md
RESOURCE_OWNER_SEQUENCER -- requirements
Module: resource_owner_sequencer

Interface
REQ-001 Parameter AGENTS, default 8: number of requesting agents and the width of the r and g vectors; legal range is 2..32.
REQ-002 Parameter BURST, default 4: number of beats the resource is held per grant; legal range is 1..256.
REQ-003 Parameter IDW, default $clog2(AGENTS): width of the owner index.
REQ-004 Port clock, input, width 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, width 1: synchronous, active-low reset sampled on the rising edge of clock.
REQ-006 Port r, input, width AGENTS: live request vector, the same vector driven into the arbiter.
REQ-007 Port g, input, width AGENTS: registered one-hot grant vector produced by the arbiter.
REQ-008 Port owner_valid, output, width 1: the resource is currently owned.
REQ-009 Port owner_id, output, width IDW: binary index of the current owner.
REQ-010 Port beat, output, width 8: current beat index within the tenure.
REQ-011 Port done, output, width AGENTS: one-hot, one-cycle tenure-complete pulse to the owning agent.
REQ-012 Port grant_error, output, width 1: sticky flag for a malformed grant.
REQ-013 Port drop_count, output, width 8: saturating count of grant cycles ignored while not IDLE.

Function
REQ-014 The sequencer SHALL implement a registered FSM with exactly three states: IDLE, BUSY and DONE.
REQ-015 In IDLE, a g that is nonzero and exactly one-hot SHALL cause the next state to be BUSY, with owner_id set to the index of the set bit, owner_valid=1 and beat=0.
REQ-016 In IDLE, a g that is multi-hot, or that contains X/Z bits, SHALL be rejected: state stays IDLE and grant_error is set to 1 on the next edge.
REQ-017 In IDLE, g=0 SHALL leave the state and all outputs unchanged.
REQ-018 In BUSY, beat SHALL increment by 1 each cycle.
REQ-019 BUSY SHALL transition to DONE when beat==BURST-1, giving exactly BURST cycles of BUSY for a full tenure.
REQ-020 Early release: in BUSY, if r[owner_id]==0 is sampled at an edge, the next state SHALL be DONE, regardless of beat.
REQ-021 If early release and beat==BURST-1 occur together, the next state SHALL be DONE with a single done pulse.
REQ-022 In DONE, done[owner_id] SHALL be 1 for exactly that one cycle, with all other done bits 0.
REQ-023 In DONE, owner_valid SHALL remain 1 and owner_id SHALL hold its value.
REQ-024 DONE SHALL always transition to IDLE on the next edge; on entry to IDLE, owner_valid=0 and beat=0.
REQ-025 Any cycle in BUSY or DONE with g!=0 SHALL be ignored for ownership and SHALL increment drop_count.
REQ-026 drop_count SHALL saturate at 255.
REQ-027 A grant in DONE SHALL NOT be accepted; it is counted as dropped, and the earliest new acceptance is in the following IDLE cycle.
REQ-028 With BURST=1, BUSY SHALL last exactly one cycle and then DONE follows.
REQ-029 done SHALL be 0 in the IDLE and BUSY states.
REQ-030 owner_id SHALL be 0 whenever owner_valid is 0.
REQ-031 grant_error SHALL be cleared only by reset.

Reset
REQ-032 When reset==0 at a rising edge, the state SHALL become IDLE and the outputs SHALL be owner_valid=0, owner_id=0, beat=0, done=0, grant_error=0 and drop_count=0.
REQ-033 Reset SHALL take priority over every other transition, including mid-BUSY and in DONE.
REQ-034 No done pulse SHALL be emitted for a tenure aborted by reset.
REQ-035 While reset==0, g and r SHALL be ignored.
REQ-036 The first edge with reset==1 SHALL behave as IDLE.

Verification (AGENTS=8, BURST=4)
REQ-037 Full tenure: reset released; r=0000_0100 held; g=0000_0100 for one cycle -> owner_valid=1 and owner_id=2 for 5 cycles; beat 0,1,2,3 over the BUSY cycles; done=0000_0100 on the 5th cycle; then IDLE.
REQ-038 Early release: grant on agent 5, then r[5] dropped after 2 BUSY cycles -> DONE on the next cycle, done=0010_0000, then owner_valid=0.
REQ-039 Dropped grants: while BUSY, g=0000_0001 driven for 3 cycles -> owner unchanged and drop_count=3; g driven in the DONE cycle -> drop_count=4 and no acceptance.
REQ-040 Malformed grant: in IDLE, g=0001_0010 -> state stays IDLE and grant_error=1 and stays 1 after later valid tenures; the same result for g containing X.
REQ-041 Reset mid-tenure: reset=0 asserted at beat 2 -> all outputs zero on the next edge with no done pulse; g=1000_0000 after reset release -> owner_id=7.
REQ-042 Saturation: 300 ignored grant cycles across tenures -> drop_count=255.
